// File: rtl/exc_commit_pkg.sv
// Shared definitions for the exception commit block: ExcType codes, ExcCode values,
// CP0 addresses, Status/Cause field positions, vector offsets and the pending-request record.
package exc_commit_pkg;

    localparam int EXC_TYPE_W = 5;

    typedef enum logic [EXC_TYPE_W-1:0] {
        EXC_NONE = 5'd0,
        EXC_INTR = 5'd1,
        EXC_ADEL = 5'd2,
        EXC_ADES = 5'd3,
        EXC_TLBR = 5'd4,
        EXC_TLBI = 5'd5,
        EXC_TLBM = 5'd6,
        EXC_CPU  = 5'd7,
        EXC_RI   = 5'd8,
        EXC_OV   = 5'd9,
        EXC_TRAP = 5'd10,
        EXC_SYSC = 5'd11,
        EXC_BP   = 5'd12,
        EXC_ERET = 5'd13
    } exc_type_e;

    localparam logic [4:0] CODE_INT  = 5'd0;
    localparam logic [4:0] CODE_MOD  = 5'd1;
    localparam logic [4:0] CODE_TLBL = 5'd2;
    localparam logic [4:0] CODE_TLBS = 5'd3;
    localparam logic [4:0] CODE_ADEL = 5'd4;
    localparam logic [4:0] CODE_ADES = 5'd5;
    localparam logic [4:0] CODE_SYS  = 5'd8;
    localparam logic [4:0] CODE_BP   = 5'd9;
    localparam logic [4:0] CODE_RI   = 5'd10;
    localparam logic [4:0] CODE_CPU  = 5'd11;
    localparam logic [4:0] CODE_OV   = 5'd12;
    localparam logic [4:0] CODE_TR   = 5'd13;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_EPC    = 5'd14;
    localparam logic [4:0] CP0_EBASE  = 5'd15;

    localparam int STATUS_EXL    = 1;
    localparam int STATUS_ERL    = 2;
    localparam int STATUS_BEV    = 22;
    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_EXC_MSB = 6;
    localparam int CAUSE_BD      = 31;

    localparam logic [31:0] STATUS_RESET    = (32'd1 << STATUS_BEV) | (32'd1 << STATUS_ERL);
    localparam logic [31:0] EBASE_RESET     = 32'h8000_0000;
    localparam logic [31:0] BEV_BASE_OFS    = 32'h0000_0200;
    localparam logic [31:0] VEC_OFS_TLBR    = 32'h0000_0000;
    localparam logic [31:0] VEC_OFS_GENERAL = 32'h0000_0180;

    typedef struct packed {
        exc_type_e   exc_type;
        logic [31:0] baddr;
        logic        save;
        logic [31:0] pc;
        logic        in_delay;
        logic        is_store;
    } exc_req_t;

    function automatic logic [4:0] exc_code(input exc_type_e t, input logic is_store);
        case (t)
            EXC_INTR:           return CODE_INT;
            EXC_TLBM:           return CODE_MOD;
            EXC_TLBR, EXC_TLBI: return is_store ? CODE_TLBS : CODE_TLBL;
            EXC_ADEL:           return CODE_ADEL;
            EXC_ADES:           return CODE_ADES;
            EXC_SYSC:           return CODE_SYS;
            EXC_BP:             return CODE_BP;
            EXC_RI:             return CODE_RI;
            EXC_CPU:            return CODE_CPU;
            EXC_OV:             return CODE_OV;
            EXC_TRAP:           return CODE_TR;
            default:            return CODE_INT;
        endcase
    endfunction

endpackage

// File: rtl/exc_commit_vector.sv
// Combinational exception vector: base chosen by Status.BEV (boot base or EBase),
// offset 0x000 only for a TLB refill taken with EXL clear, else 0x180.
module exc_vector
    import exc_commit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
    input  exc_type_e   i_exc_type,
    input  logic        i_bev,
    input  logic        i_exl,
    input  logic [19:0] i_ebase_hi,
    output logic [31:0] o_vector
);

    logic [31:0] w_base;
    logic [31:0] w_ofs;

    assign w_base   = i_bev ? (RESET_VECTOR + BEV_BASE_OFS) : {i_ebase_hi, 12'h000};
    assign w_ofs    = (i_exc_type == EXC_TLBR && !i_exl) ? VEC_OFS_TLBR : VEC_OFS_GENERAL;
    assign o_vector = w_base + w_ofs;

endmodule

// File: rtl/exc_commit.sv
// Memory-stage exception/ERET commit: updates CP0 EPC/BadVAddr/Status/Cause and issues a
// one-cycle flush with the redirect target. Define EXC_COMMIT_EBASE_EN to make EBase writable.
module exc_commit
    import exc_commit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_flag,
    input  logic [4:0]  exc_type,
    input  logic [31:0] exc_baddr,
    input  logic        exc_save,
    input  logic [31:0] pc,
    input  logic        in_delay,
    input  logic        is_store,
    input  logic        stall,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_waddr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] epc,
    output logic [31:0] badvaddr,
    output logic [31:0] status,
    output logic [31:0] cause,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_FLUSH} state_e;

    state_e      r_state;
    state_e      w_state_nxt;
    exc_req_t    r_pend;
    exc_req_t    w_live;
    exc_req_t    w_req;
    logic        w_live_event;
    logic        w_commit;
    logic        w_latch;
    logic        w_is_eret;
    logic [31:0] w_vector;
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;
    logic [31:0] r_status;
    logic [31:0] r_cause;
    logic [19:0] r_ebase_hi;
    logic [31:0] r_redirect;

    always_comb begin
        w_live.exc_type = exc_type_e'(exc_type);
        w_live.baddr    = exc_baddr;
        w_live.save     = exc_save;
        w_live.pc       = pc;
        w_live.in_delay = in_delay;
        w_live.is_store = is_store;
    end

    assign w_live_event = exc_flag && (exc_type != EXC_NONE);
    assign w_req        = (r_state == ST_HOLD) ? r_pend : w_live;
    assign w_is_eret    = (w_req.exc_type == EXC_ERET);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_live_event) begin
                    if (stall) begin
                        w_latch     = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_commit    = 1'b1;
                        w_state_nxt = ST_FLUSH;
                    end
                end
            end
            ST_HOLD: begin
                if (!stall) begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The pending set is a handful of flops, cleared so a reset mid-event leaves nothing behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
        end else if (w_latch) begin
            r_pend <= w_live;
        end
    end

    exc_vector #(
        .RESET_VECTOR (RESET_VECTOR)
    ) u_vector (
        .i_exc_type (w_req.exc_type),
        .i_bev      (r_status[STATUS_BEV]),
        .i_exl      (r_status[STATUS_EXL]),
        .i_ebase_hi (r_ebase_hi),
        .o_vector   (w_vector)
    );

    // NOTE: non-blocking assignments; the commit updates are written after the MTC0 write so the
    // later assignment to an overlapping field takes effect and the commit wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_epc      <= '0;
            r_badvaddr <= '0;
            r_cause    <= '0;
            r_status   <= STATUS_RESET;
            r_ebase_hi <= EBASE_RESET[31:12];
            r_redirect <= '0;
        end else begin
            if (cp0_we) begin
                case (cp0_waddr)
                    CP0_EPC:    r_epc    <= cp0_wdata;
                    CP0_STATUS: r_status <= cp0_wdata;
`ifdef EXC_COMMIT_EBASE_EN
                    CP0_EBASE:  r_ebase_hi <= {2'b10, cp0_wdata[29:12]};
`endif
                    default: ;
                endcase
            end
            if (w_commit) begin
                if (w_is_eret) begin
                    r_status[STATUS_EXL] <= 1'b0;
                    r_redirect           <= r_epc;
                end else begin
                    r_status[STATUS_EXL]                  <= 1'b1;
                    r_cause[CAUSE_EXC_MSB:CAUSE_EXC_LSB]  <= exc_code(w_req.exc_type, w_req.is_store);
                    r_redirect                            <= w_vector;
                    // A nested exception (EXL already set) must not clobber the original return point.
                    if (!r_status[STATUS_EXL]) begin
                        r_epc             <= w_req.in_delay ? (w_req.pc - 32'd4) : w_req.pc;
                        r_cause[CAUSE_BD] <= w_req.in_delay;
                    end
                    if (w_req.save) begin
                        r_badvaddr <= w_req.baddr;
                    end
                end
            end
        end
    end

    assign epc         = r_epc;
    assign badvaddr    = r_badvaddr;
    assign status      = r_status;
    assign cause       = r_cause;
    assign redirect_pc = r_redirect;
    assign flush       = (r_state == ST_FLUSH);
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_exc_commit.sv
// Self-checking bench for exc_commit: directed scenarios then random traffic, all compared
// against a transaction-level reference model of the CP0 exception rules.
module tb_exc_commit;
    import exc_commit_pkg::*;

    localparam logic [31:0] RV = 32'hBFC0_0000;
`ifdef EXC_COMMIT_EBASE_EN
    localparam bit EBASE_EN = 1'b1;
`else
    localparam bit EBASE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_flag;
    logic [4:0]  exc_type;
    logic [31:0] exc_baddr;
    logic        exc_save;
    logic [31:0] pc;
    logic        in_delay;
    logic        is_store;
    logic        stall;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic [31:0] epc, badvaddr, status, cause, redirect_pc;
    logic        flush, busy;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] m_epc, m_bad, m_status, m_cause, m_ebase, m_redirect;
    bit          m_flush, m_hold;
    logic [4:0]  p_type;
    logic [31:0] p_pc, p_baddr;
    bit          p_dly, p_st, p_save;

    exc_commit #(.RESET_VECTOR(RV)) dut (
        .clk         (clk),
        .rst         (rst),
        .exc_flag    (exc_flag),
        .exc_type    (exc_type),
        .exc_baddr   (exc_baddr),
        .exc_save    (exc_save),
        .pc          (pc),
        .in_delay    (in_delay),
        .is_store    (is_store),
        .stall       (stall),
        .cp0_we      (cp0_we),
        .cp0_waddr   (cp0_waddr),
        .cp0_wdata   (cp0_wdata),
        .epc         (epc),
        .badvaddr    (badvaddr),
        .status      (status),
        .cause       (cause),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] ref_code(input logic [4:0] t, input bit st);
        case (t)
            EXC_INTR: return 5'd0;
            EXC_TLBM: return 5'd1;
            EXC_TLBR: return st ? 5'd3 : 5'd2;
            EXC_TLBI: return st ? 5'd3 : 5'd2;
            EXC_ADEL: return 5'd4;
            EXC_ADES: return 5'd5;
            EXC_SYSC: return 5'd8;
            EXC_BP:   return 5'd9;
            EXC_RI:   return 5'd10;
            EXC_CPU:  return 5'd11;
            EXC_OV:   return 5'd12;
            EXC_TRAP: return 5'd13;
            default:  return 5'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_vector(input logic [4:0] t, input logic [31:0] st, input logic [31:0] eb);
        logic [31:0] base;
        if (st[22])        base = RV + 32'h200;
        else if (EBASE_EN) base = {eb[31:12], 12'h000};
        else               base = 32'h8000_0000;
        return base + ((t == EXC_TLBR && !st[1]) ? 32'h0 : 32'h180);
    endfunction

    task automatic model_reset();
        m_epc = 0; m_bad = 0; m_cause = 0; m_status = 32'h0040_0004;
        m_ebase = 32'h8000_0000; m_redirect = 0; m_flush = 0; m_hold = 0;
    endtask

    // Effect of the coming clock edge, from the inputs currently driven.
    task automatic model_edge();
        logic [31:0] n_epc, n_bad, n_status, n_cause, n_ebase;
        logic [4:0]  t;
        logic [31:0] c_pc, c_ba;
        bit          c_dly, c_st, c_save, go;
        n_epc = m_epc; n_bad = m_bad; n_status = m_status; n_cause = m_cause; n_ebase = m_ebase;
        if (cp0_we) begin
            if (cp0_waddr == 5'd14) n_epc = cp0_wdata;
            if (cp0_waddr == 5'd12) n_status = cp0_wdata;
            if (cp0_waddr == 5'd15 && EBASE_EN) n_ebase = {2'b10, cp0_wdata[29:12], 12'h000};
        end
        go = 0;
        t = 0; c_pc = 0; c_ba = 0; c_dly = 0; c_st = 0; c_save = 0;
        if (m_flush) begin
            go = 0;
        end else if (m_hold) begin
            if (!stall) begin
                go = 1; m_hold = 0;
                t = p_type; c_pc = p_pc; c_ba = p_baddr; c_dly = p_dly; c_st = p_st; c_save = p_save;
            end
        end else if (exc_flag && exc_type != 5'd0) begin
            t = exc_type; c_pc = pc; c_ba = exc_baddr; c_dly = in_delay; c_st = is_store; c_save = exc_save;
            if (stall) begin
                m_hold = 1;
                p_type = t; p_pc = c_pc; p_baddr = c_ba; p_dly = c_dly; p_st = c_st; p_save = c_save;
            end else begin
                go = 1;
            end
        end
        if (go) begin
            if (t == EXC_ERET) begin
                n_status[1] = 1'b0;
                m_redirect  = m_epc;
            end else begin
                n_status[1]   = 1'b1;
                n_cause[6:2]  = ref_code(t, c_st);
                m_redirect    = ref_vector(t, m_status, m_ebase);
                if (!m_status[1]) begin
                    n_epc       = c_dly ? c_pc - 32'd4 : c_pc;
                    n_cause[31] = c_dly;
                end
                if (c_save) n_bad = c_ba;
            end
        end
        m_flush = go;
        m_epc = n_epc; m_bad = n_bad; m_status = n_status; m_cause = n_cause; m_ebase = n_ebase;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".flush"}, {31'd0, flush}, {31'd0, m_flush});
        check({tag, ".busy"}, {31'd0, busy}, {31'd0, (m_flush || m_hold)});
        check({tag, ".epc"}, epc, m_epc);
        check({tag, ".badvaddr"}, badvaddr, m_bad);
        check({tag, ".status"}, status, m_status);
        check({tag, ".cause"}, cause, m_cause);
        if (m_flush) check({tag, ".redirect"}, redirect_pc, m_redirect);
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        exc_flag = 0; exc_type = 0; exc_baddr = 0; exc_save = 0; pc = 0;
        in_delay = 0; is_store = 0; stall = 0; cp0_we = 0; cp0_waddr = 0; cp0_wdata = 0;
    endtask

    task automatic set_exc(input logic [4:0] t, input logic [31:0] p, input bit dly,
                           input bit st, input logic [31:0] ba, input bit sv);
        exc_flag = 1; exc_type = t; pc = p; in_delay = dly; is_store = st; exc_baddr = ba; exc_save = sv;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp0_we = 1; cp0_waddr = a; cp0_wdata = d;
    endtask

    task automatic reset_mid_cycle(input string tag);
        #2 rst = 1;
        #1;
        model_reset();
        check_all(tag);
        check({tag, ".redirect"}, redirect_pc, 32'h0);
        rst = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        model_reset();
        #3;
        check_all("reset");
        check("reset.redirect", redirect_pc, 32'h0);
        check("reset.status_const", status, 32'h0040_0004);
        rst = 0;

        // Basic syscall with Status cleared
        mtc0(CP0_STATUS, 32'h0); step("mtc0_status");
        idle_inputs(); set_exc(EXC_SYSC, 32'h8000_1000, 0, 0, 32'h0, 0); step("sysc_commit");
        check("sysc.redirect_const", redirect_pc, 32'h8000_0180);
        check("sysc.epc_const", epc, 32'h8000_1000);
        check("sysc.code_const", {27'd0, cause[6:2]}, 32'd8);
        idle_inputs(); step("sysc_flush_end");

        // TLB refill on a store, EXL clear
        mtc0(CP0_STATUS, 32'h0); step("mtc0_status2");
        idle_inputs(); set_exc(EXC_TLBR, 32'h0040_0100, 0, 1, 32'h0040_0010, 1); step("tlbr_commit");
        check("tlbr.redirect_const", redirect_pc, 32'h8000_0000);
        check("tlbr.badvaddr_const", badvaddr, 32'h0040_0010);
        idle_inputs(); step("tlbr_flush_end");

        // Delay-slot overflow, then ERET
        mtc0(CP0_STATUS, 32'h0); step("mtc0_status3");
        idle_inputs(); set_exc(EXC_OV, 32'h8000_2004, 1, 0, 32'h0, 0); step("ov_commit");
        check("ov.epc_const", epc, 32'h8000_2000);
        check("ov.bd_const", {31'd0, cause[31]}, 32'd1);
        idle_inputs(); step("ov_flush_end");
        set_exc(EXC_ERET, 32'h0, 0, 0, 32'h0, 0); step("eret_commit");
        check("eret.redirect_const", redirect_pc, 32'h8000_2000);
        idle_inputs(); step("eret_flush_end");

        // Syscall held by stall for three cycles, second pulse ignored
        set_exc(EXC_SYSC, 32'h8000_3000, 0, 0, 32'h0, 0); stall = 1; step("hold1");
        exc_flag = 0; step("hold2");
        set_exc(EXC_BP, 32'h8000_4000, 0, 0, 32'h1234_5678, 1); step("hold3_pulse");
        stall = 0; step("hold_commit");
        check("hold.code_const", {27'd0, cause[6:2]}, 32'd8);
        idle_inputs(); step("hold_flush_end");

        // NoExc with flag raised is no event
        set_exc(EXC_NONE, 32'h8000_5000, 0, 0, 32'h0, 1); step("noexc");
        idle_inputs();

        // EBase write then interrupt with BEV=0 and a same-cycle Status write
        mtc0(CP0_EBASE, 32'h9FC0_3000); step("mtc0_ebase");
        mtc0(CP0_STATUS, 32'h0); step("mtc0_status4");
        idle_inputs(); set_exc(EXC_INTR, 32'h8000_6000, 0, 0, 32'h0, 0);
        mtc0(CP0_STATUS, 32'h0000_FF00); step("intr_commit");
        check("intr.status_const", status, 32'h0000_FF02);
        if (EBASE_EN) check("intr.redirect_ebase", redirect_pc, 32'h9FC0_3180);
        else          check("intr.redirect_fixed", redirect_pc, 32'h8000_0180);
        idle_inputs(); step("intr_flush_end");

        // Reset raised in the flush cycle
        mtc0(CP0_STATUS, 32'h0); step("mtc0_status5");
        idle_inputs(); set_exc(EXC_RI, 32'h8000_7000, 0, 0, 32'h0, 0); step("ri_commit");
        reset_mid_cycle("rst_in_flush");
        idle_inputs(); step("after_reset");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) reset_mid_cycle("rand_reset");
            exc_flag  = ($urandom_range(0, 9) < 3);
            exc_type  = 5'($urandom_range(0, 13));
            exc_baddr = $urandom;
            exc_save  = $urandom_range(0, 1);
            pc        = $urandom;
            in_delay  = $urandom_range(0, 1);
            is_store  = $urandom_range(0, 1);
            stall     = ($urandom_range(0, 9) < 3);
            cp0_we    = ($urandom_range(0, 9) < 2);
            case ($urandom_range(0, 4))
                0: cp0_waddr = 5'd12;
                1: cp0_waddr = 5'd13;
                2: cp0_waddr = 5'd14;
                3: cp0_waddr = 5'd15;
                default: cp0_waddr = 5'($urandom_range(0, 31));
            endcase
            cp0_wdata = $urandom;
            step("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exc_commit.md
EXC_COMMIT -- requirements
Module: exc_commit

Interface
REQ-001 Parameter RESET_VECTOR, default 32'hBFC00000, boot vector; it also fixes the BEV=1 exception base at RESET_VECTOR+32'h200.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 exc_flag  in  1  an exception or ERET is present at the memory stage.
REQ-005 exc_type  in  5  ExcType code: NoExc, Intr, AdEL, AdES, TLBR, TLBI, TLBM, CpU, RI, Ov, Trap, SysC, Bp, ERET.
REQ-006 exc_baddr  in  32  faulting virtual address.
REQ-007 exc_save  in  1  BadVAddr shall be written for this exception.
REQ-008 pc  in  32  PC of the excepting instruction.
REQ-009 in_delay  in  1  excepting instruction is in a branch delay slot.
REQ-010 is_store  in  1  faulting access is a store; selects TLBS over TLBL.
REQ-011 stall  in  1  memory stage stalled; no commit allowed this cycle.
REQ-012 cp0_we / cp0_waddr / cp0_wdata  in  1/5/32  MTC0 port: EPC=14, Status=12, EBase=15; other addresses ignored.
REQ-013 epc, badvaddr, status, cause  out  32 each  architectural CP0 register values.
REQ-014 flush  out  1  one-cycle pipeline flush pulse.
REQ-015 redirect_pc  out  32  fetch target; valid only while flush=1.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 FSM states: IDLE, HOLD, FLUSH.
REQ-018 IDLE, exc_flag=1 and stall=0: commit at this edge, then go to FLUSH.
REQ-019 IDLE, exc_flag=1 and stall=1: latch all inputs into the pending set, then go to HOLD.
REQ-020 HOLD: commit from the pending set in the first cycle with stall=0, then go to FLUSH; new inputs are ignored while in HOLD.
REQ-021 FLUSH: flush=1 for exactly one cycle with redirect_pc registered, then return to IDLE; exc_flag is ignored in FLUSH.
REQ-022 Commit latency: flush appears exactly one cycle after the commit edge.
REQ-023 Commit of a non-ERET exception when Status.EXL=0:
- in_delay=0: EPC=pc, Cause.BD=0.
- in_delay=1: EPC=pc-4 (modulo 2^32), Cause.BD=1.
REQ-024 Commit of a non-ERET exception when Status.EXL=1: EPC and Cause.BD keep their values.
REQ-025 Every non-ERET commit sets Status.EXL=1 and writes Cause.ExcCode:
- Intr 0, TLBM 1, TLBR/TLBI 2 (load) or 3 (store), AdEL 4, AdES 5.
- Sys 8, Bp 9, RI 10, CpU 11, Ov 12, Tr 13.
REQ-026 exc_save=1 writes BadVAddr=exc_baddr; otherwise BadVAddr is held.
REQ-027 Vector base: Status.BEV=1 gives RESET_VECTOR+32'h200; BEV=0 gives 32'h80000000 (see REQ-033 for the alternative).
REQ-028 Vector offset: TLBR with prior EXL=0 uses +0x000; all other cases use +0x180.
REQ-029 ERET commit: Status.EXL=0, redirect_pc=EPC; no other register changes.
REQ-030 A commit and an MTC0 write in the same cycle: the commit wins on every overlapping field; the MTC0 write applies only to the non-overlapping fields.
REQ-031 exc_type=NoExc with exc_flag=1 shall be treated as no event.

Reset
REQ-032 On rst:
- FSM=IDLE; flush=0, busy=0, redirect_pc=0.
- EPC=0, BadVAddr=0, Cause=0.
- Status=32'h00400004 (BEV=1, ERL=1).
- EBase=32'h80000000.
- Pending set cleared, so a reset during HOLD or FLUSH discards the event.

Configuration
REQ-033 EXC_COMMIT_EBASE_EN defined:
- EBase is writable at address 15; bits [29:12] only, bits [31:30] fixed at 2'b10.
- BEV=0 base = {EBase[31:12],12'h000}.
REQ-034 EXC_COMMIT_EBASE_EN undefined: EBase write ignored; BEV=0 base fixed at 32'h80000000.

Structure
REQ-035 The shared defines package holds:
- ExcType codes and their width.
- ExcCode values.
- CP0 register addresses.
- Status/Cause bit-field positions.
- Vector offsets.
REQ-036 One sub-module, exc_vector: combinational mapping of type, BEV, EXL and EBase to the vector address.

Verification
REQ-037 Status=32'h00000000, exc_type=SysC, pc=32'h80001000, in_delay=0, stall=0:
- Next cycle: flush=1, redirect_pc=32'h80000180.
- EPC=32'h80001000, ExcCode=8, EXL=1.
REQ-038 EXL=0, TLBR, is_store=1, exc_baddr=32'h00400010, exc_save=1:
- redirect_pc=32'h80000000, ExcCode=3, BadVAddr=32'h00400010.
REQ-039 in_delay=1, pc=32'h80002004, Ov:
- EPC=32'h80002000, BD=1.
- Then ERET: EXL=0, redirect_pc=32'h80002000.
REQ-040 SysC arrives with stall=1 held for 3 cycles:
- busy=1 throughout; flush appears one cycle after stall falls.
- A second exc_flag pulse during HOLD is ignored.
REQ-041 Commit from IDLE (REQ-018) then rst raised in the FLUSH cycle:
- flush drops immediately; all outputs return to their REQ-032 values.
REQ-042 With EXC_COMMIT_EBASE_EN defined, MTC0 EBase=32'h9FC03000, then Intr with BEV=0:
- redirect_pc=32'h9FC03180; the MTC0 lands in the same cycle as a commit to Status and loses the EXL field.
